// File: rtl/issue_ctrl_pkg.sv
// Shared encodings and scoreboard types for the pipeline issue/hazard controller.
// Forwarding selects, divider FSM states and scoreboard entry layout live here.
package issue_ctrl_pkg;

    localparam int REG_W  = 5;
    localparam int CNT_W  = 6;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    typedef enum logic {
        DIV_IDLE = 1'b0,
        DIV_BUSY = 1'b1
    } div_state_t;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
        logic             load;
    } sb_entry_t;

    // True when a valid in-flight write targets a used source; load_only narrows it to loads.
    function automatic logic sb_hit(input sb_entry_t        e,
                                    input logic [REG_W-1:0] r,
                                    input logic             used,
                                    input logic             load_only);
        return used && e.v && (!load_only || e.load) && (e.rd == r);
    endfunction

endpackage

// File: rtl/issue_ctrl_div_sequencer.sv
// IDLE/BUSY sequencer for the multi-cycle DIV/DIVU unit.
// A start from IDLE keeps the unit busy for DIV_LAT cycles, flagging the last one with md_done.
module issue_ctrl_div_sequencer
    import issue_ctrl_pkg::*;
#(
    parameter int DIV_LAT = 8
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic start_req,
    output logic md_start,
    output logic md_busy,
    output logic md_done
);

    div_state_t       state;
    div_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= DIV_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            DIV_IDLE: begin
                if (start_req) begin
                    state_next = DIV_BUSY;
                    cnt_next   = CNT_W'(DIV_LAT - 1);
                end
            end
            DIV_BUSY: begin
                if (cnt == '0) begin
                    state_next = DIV_IDLE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: begin
                state_next = DIV_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Busy drops the cycle after done, which lets a waiting MFHI/MFLO issue right then.
    always_comb begin
        md_start = (state == DIV_IDLE) && start_req;
        md_busy  = (state == DIV_BUSY);
        md_done  = (state == DIV_BUSY) && (cnt == '0);
    end

endmodule

// File: rtl/issue_ctrl.sv
// Issue/hazard controller between decode and ID/EX: scoreboard of in-flight writes,
// load-use and HI/LO interlocks, registered forwarding selects, fetch squash and divider sequencing.
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int DIV_LAT   = 8,
    parameter bit FORWARD   = 1'b1,
    parameter bit WB_BYPASS = 1'b1
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_src1,
    input  logic             id_src2,
    input  logic             id_rwe,
    input  logic             id_load,
    input  logic             id_div,
    input  logic             id_hilo_rd,
    input  logic             ex_redirect,
    output logic             stall,
    output logic             flush_if,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             md_start,
    output logic             md_busy,
    output logic             md_done
);

    sb_entry_t  ex_e;
    sb_entry_t  mem_e;
    sb_entry_t  id_e;
    logic       rs_used;
    logic       rt_used;
    logic       wb_hit;
    logic       data_hazard;
    logic       div_issue;
    logic [1:0] fwd_a_next;
    logic [1:0] fwd_b_next;

    assign rs_used = id_src1 && (id_rs != '0);
    assign rt_used = id_src2 && (id_rt != '0);

    assign id_e.v    = id_valid && id_rwe && (id_dest != '0);
    assign id_e.rd   = id_dest;
    assign id_e.load = id_load;

    // The WB slot only matters when nothing bypasses and the register file reads before it writes.
    if (!FORWARD && !WB_BYPASS) begin : g_wb
        sb_entry_t wb_e;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                wb_e <= '0;
            end else begin
                wb_e <= mem_e;
            end
        end

        assign wb_hit = sb_hit(wb_e, id_rs, rs_used, 1'b0) || sb_hit(wb_e, id_rt, rt_used, 1'b0);
    end else begin : g_no_wb
        assign wb_hit = 1'b0;
    end

    always_comb begin
        data_hazard = 1'b0;
        if (FORWARD) begin
            data_hazard = sb_hit(ex_e, id_rs, rs_used, 1'b1) || sb_hit(ex_e, id_rt, rt_used, 1'b1);
        end else begin
            data_hazard = sb_hit(ex_e,  id_rs, rs_used, 1'b0) || sb_hit(ex_e,  id_rt, rt_used, 1'b0) ||
                          sb_hit(mem_e, id_rs, rs_used, 1'b0) || sb_hit(mem_e, id_rt, rt_used, 1'b0) ||
                          wb_hit;
        end
    end

    assign stall     = id_valid && (data_hazard || (md_busy && (id_hilo_rd || id_div)));
    assign flush_if  = ex_redirect;
    assign div_issue = id_valid && id_div && !stall;

    // The EX entry becomes MEM next cycle, so it is the nearest producer and is checked first.
    always_comb begin
        fwd_a_next = FWD_RF;
        fwd_b_next = FWD_RF;
        if (FORWARD && id_valid && !stall) begin
            if (sb_hit(ex_e, id_rs, rs_used, 1'b0)) begin
                fwd_a_next = FWD_MEM;
            end else if (sb_hit(mem_e, id_rs, rs_used, 1'b0)) begin
                fwd_a_next = FWD_WB;
            end
            if (sb_hit(ex_e, id_rt, rt_used, 1'b0)) begin
                fwd_b_next = FWD_MEM;
            end else if (sb_hit(mem_e, id_rt, rt_used, 1'b0)) begin
                fwd_b_next = FWD_WB;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_e  <= '0;
            mem_e <= '0;
            fwd_a <= FWD_RF;
            fwd_b <= FWD_RF;
        end else begin
            mem_e <= ex_e;
            ex_e  <= stall ? '0 : id_e;
            fwd_a <= fwd_a_next;
            fwd_b <= fwd_b_next;
        end
    end

    issue_ctrl_div_sequencer #(
        .DIV_LAT (DIV_LAT)
    ) u_div_sequencer (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_req (div_issue),
        .md_start  (md_start),
        .md_busy   (md_busy),
        .md_done   (md_done)
    );

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: directed hazard scenarios followed by random traffic,
// all compared against an instruction-level pipeline and divider model.
module tb_issue_ctrl;

    localparam int DIV_LAT   = 8;
    localparam bit FORWARD   = 1'b1;
    localparam bit WB_BYPASS = 1'b1;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [4:0] id_dest;
    logic       id_src1;
    logic       id_src2;
    logic       id_rwe;
    logic       id_load;
    logic       id_div;
    logic       id_hilo_rd;
    logic       ex_redirect;
    logic       stall;
    logic       flush_if;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       md_start;
    logic       md_busy;
    logic       md_done;

    typedef struct {
        logic       writes;
        logic [4:0] dest;
        logic       load;
        logic [1:0] fa;
        logic [1:0] fb;
    } instr_t;

    instr_t pipe [3];
    int     div_left;
    int     n_compared;
    int     n_mismatched;
    int     rnd;

    logic       obs_stall;
    logic       obs_flush;
    logic       obs_start;
    logic       obs_busy;
    logic       obs_done;
    logic [1:0] obs_fa;
    logic [1:0] obs_fb;

    issue_ctrl #(
        .DIV_LAT   (DIV_LAT),
        .FORWARD   (FORWARD),
        .WB_BYPASS (WB_BYPASS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_dest     (id_dest),
        .id_src1     (id_src1),
        .id_src2     (id_src2),
        .id_rwe      (id_rwe),
        .id_load     (id_load),
        .id_div      (id_div),
        .id_hilo_rd  (id_hilo_rd),
        .ex_redirect (ex_redirect),
        .stall       (stall),
        .flush_if    (flush_if),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .md_start    (md_start),
        .md_busy     (md_busy),
        .md_done     (md_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [1:0] observed, input logic [1:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] dest, input logic s1, input logic s2,
                                 input logic rwe, input logic ld, input logic dv,
                                 input logic hl, input logic redir);
        id_valid    = v;
        id_rs       = rs;
        id_rt       = rt;
        id_dest     = dest;
        id_src1     = s1;
        id_src2     = s2;
        id_rwe      = rwe;
        id_load     = ld;
        id_div      = dv;
        id_hilo_rd  = hl;
        ex_redirect = redir;
    endtask

    task automatic applyNop();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic resetModel();
        for (int s = 0; s < 3; s++) begin
            pipe[s] = '{writes: 1'b0, dest: 5'd0, load: 1'b0, fa: 2'd0, fb: 2'd0};
        end
        div_left = 0;
    endtask

    // Searches the older instructions (EX first, then MEM, then WB) for a producer of r.
    function automatic logic producerHit(input int depth, input logic used, input logic [4:0] r,
                                         input logic load_only);
        for (int s = 0; s < depth; s++) begin
            if (used && pipe[s].writes && (!load_only || pipe[s].load) && pipe[s].dest == r) begin
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic logic [1:0] fwdSel(input logic used, input logic [4:0] r);
        if (!FORWARD || !used) begin
            return 2'd0;
        end
        for (int s = 0; s < 2; s++) begin
            if (pipe[s].writes && pipe[s].dest == r) begin
                return 2'(s + 1);
            end
        end
        return 2'd0;
    endfunction

    task automatic runCycle();
        logic   rs_used;
        logic   rt_used;
        logic   hazard;
        logic   e_busy;
        logic   e_done;
        logic   e_stall;
        logic   e_start;
        instr_t nxt;

        @(negedge clk);
        rs_used = id_src1 && (id_rs != 5'd0);
        rt_used = id_src2 && (id_rt != 5'd0);
        if (FORWARD) begin
            hazard = producerHit(1, rs_used, id_rs, 1'b1) || producerHit(1, rt_used, id_rt, 1'b1);
        end else begin
            hazard = producerHit(WB_BYPASS ? 2 : 3, rs_used, id_rs, 1'b0) ||
                     producerHit(WB_BYPASS ? 2 : 3, rt_used, id_rt, 1'b0);
        end
        e_busy  = (div_left > 0);
        e_done  = (div_left == 1);
        e_stall = id_valid && (hazard || (e_busy && (id_hilo_rd || id_div)));
        e_start = id_valid && id_div && !e_stall;

        obs_stall = stall;
        obs_flush = flush_if;
        obs_start = md_start;
        obs_busy  = md_busy;
        obs_done  = md_done;
        obs_fa    = fwd_a;
        obs_fb    = fwd_b;

        checkOutput("stall",    {1'b0, stall},    {1'b0, e_stall});
        checkOutput("flush_if", {1'b0, flush_if}, {1'b0, ex_redirect});
        checkOutput("md_start", {1'b0, md_start}, {1'b0, e_start});
        checkOutput("md_busy",  {1'b0, md_busy},  {1'b0, e_busy});
        checkOutput("md_done",  {1'b0, md_done},  {1'b0, e_done});
        checkOutput("fwd_a",    fwd_a,            pipe[0].fa);
        checkOutput("fwd_b",    fwd_b,            pipe[0].fb);

        if (!rst_n) begin
            resetModel();
        end else begin
            if (e_start) begin
                div_left = DIV_LAT;
            end else if (div_left > 0) begin
                div_left--;
            end
            nxt = '{writes: 1'b0, dest: 5'd0, load: 1'b0, fa: 2'd0, fb: 2'd0};
            if (id_valid && !e_stall) begin
                nxt.writes = id_rwe && (id_dest != 5'd0);
                nxt.dest   = id_dest;
                nxt.load   = id_load;
                nxt.fa     = fwdSel(rs_used, id_rs);
                nxt.fb     = fwdSel(rt_used, id_rt);
            end
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = nxt;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) begin
            applyNop();
            runCycle();
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst_n        = 1'b0;
        applyNop();
        resetModel();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;

        $display("[TB] reset state");
        runCycle();
        checkOutput("reset_busy", {1'b0, obs_busy}, 2'd0);
        checkOutput("reset_fwd_a", obs_fa, 2'd0);
        rst_n = 1'b1;
        drain();

        $display("[TB] load-use: LW r5 then ADD r6,r5,r7");
        applyStimulus(1'b1, 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        runCycle();
        applyStimulus(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runCycle();
        checkOutput("lu_stall_on", {1'b0, obs_stall}, 2'd1);
        runCycle();
        checkOutput("lu_stall_off", {1'b0, obs_stall}, 2'd0);
        applyNop();
        runCycle();
        checkOutput("lu_fwd_a", obs_fa, 2'd2);
        checkOutput("lu_fwd_b", obs_fb, 2'd0);
        drain();

        $display("[TB] ALU chain: ADDU r3,r1,r2; SUB r4,r3,r3");
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runCycle();
        applyStimulus(1'b1, 5'd3, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runCycle();
        checkOutput("alu_no_stall", {1'b0, obs_stall}, 2'd0);
        applyNop();
        runCycle();
        checkOutput("alu_fwd_a_mem", obs_fa, 2'd1);
        checkOutput("alu_fwd_b_mem", obs_fb, 2'd1);
        drain();

        $display("[TB] ALU chain with an independent op in between");
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runCycle();
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runCycle();
        applyStimulus(1'b1, 5'd3, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runCycle();
        applyNop();
        runCycle();
        checkOutput("alu_fwd_a_wb", obs_fa, 2'd2);
        checkOutput("alu_fwd_b_wb", obs_fb, 2'd2);
        drain();

        $display("[TB] r0 writes: ADDIU r0 then OR r1,r0,r0");
        applyStimulus(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runCycle();
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runCycle();
        checkOutput("r0_no_stall", {1'b0, obs_stall}, 2'd0);
        applyNop();
        runCycle();
        checkOutput("r0_fwd_a", obs_fa, 2'd0);
        checkOutput("r0_fwd_b", obs_fb, 2'd0);
        drain();

        $display("[TB] redirect during load-use stall");
        applyStimulus(1'b1, 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        runCycle();
        applyStimulus(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        runCycle();
        checkOutput("redir_flush", {1'b0, obs_flush}, 2'd1);
        checkOutput("redir_stall", {1'b0, obs_stall}, 2'd1);
        applyStimulus(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runCycle();
        checkOutput("slot_issues", {1'b0, obs_stall}, 2'd0);
        applyNop();
        runCycle();
        checkOutput("slot_fwd_a", obs_fa, 2'd2);
        drain();

        $display("[TB] divide interlock: DIV then MFLO");
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        runCycle();
        checkOutput("div_start", {1'b0, obs_start}, 2'd1);
        for (int k = 1; k <= DIV_LAT + 1; k++) begin
            applyStimulus(1'b1, 5'd0, 5'd0, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            runCycle();
            checkOutput("div_done_cycle", {1'b0, obs_done},  {1'b0, k == DIV_LAT});
            checkOutput("div_mflo_stall", {1'b0, obs_stall}, {1'b0, k <= DIV_LAT});
            checkOutput("div_busy_cycle", {1'b0, obs_busy},  {1'b0, k <= DIV_LAT});
        end
        drain();

        $display("[TB] reset in the middle of a divide");
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        runCycle();
        for (int k = 1; k <= 3; k++) begin
            applyNop();
            runCycle();
        end
        rst_n = 1'b0;
        applyNop();
        runCycle();
        checkOutput("rst_div_busy_before", {1'b0, obs_busy}, 2'd1);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            applyNop();
            runCycle();
            checkOutput("rst_div_busy_after", {1'b0, obs_busy}, 2'd0);
            checkOutput("rst_div_no_done",    {1'b0, obs_done}, 2'd0);
        end

        $display("[TB] random instruction stream");
        for (int i = 0; i < 600; i++) begin
            rnd = int'($urandom_range(0, 99));
            applyStimulus(1'($urandom_range(0, 9) != 0),
                          5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)),
                          1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)),
                          1'(rnd >= 6),
                          1'($urandom_range(0, 3) == 0),
                          1'(rnd < 6),
                          1'(rnd >= 6 && rnd < 14),
                          1'($urandom_range(0, 9) == 0));
            runCycle();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
- Pipeline issue/hazard controller for the 5-stage MIPS core. It sits between decode and the ID/EX pipeline register.
- Tracks in-flight register writes in a 3-entry scoreboard covering EX, MEM and WB.
- Generates the load-use stall, forwarding selects, taken-branch/jump fetch squash, and HI/LO interlocks.
- Sequences the multi-cycle DIV/DIVU unit.

Parameters:
- DIV_LAT, 8: DIV/DIVU execution cycles (range 2..63).
- FORWARD, 1: 1 = EX/MEM and MEM/WB bypass enabled; 0 = stall until hazard clears.
- WB_BYPASS, 1: 1 = register file is write-before-read, so a WB-stage match is never a hazard.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  valid, non-noop instruction in ID
- id_rs  in  5  source 1 register
- id_rt  in  5  source 2 register
- id_dest  in  5  resolved destination register (rd, rt or 31)
- id_src1  in  1  instruction reads rs
- id_src2  in  1  instruction reads rt
- id_rwe  in  1  instruction writes id_dest
- id_load  in  1  instruction is LW/LB/LBU
- id_div  in  1  instruction is DIV/DIVU
- id_hilo_rd  in  1  instruction is MFHI/MFLO
- ex_redirect  in  1  taken branch or jump resolved in EX
- stall  out  1  hold PC and IF/ID; ID/EX loads a bubble
- flush_if  out  1  squash the instruction currently in IF
- fwd_a  out  2  EX operand A select: 0 regfile, 1 MEM result, 2 WB result
- fwd_b  out  2  EX operand B select, same encoding
- md_start  out  1  one-cycle divider start pulse
- md_busy  out  1  divider running
- md_done  out  1  one-cycle pulse on the final divider cycle

Behaviour:
- Reset (rst_n=0 at a clk edge): all scoreboard entries invalid, div FSM in IDLE, counter 0, every output 0.
- Scoreboard entry fields: {v, reg, load}. Each cycle EX->MEM and MEM->WB shift unconditionally.
- ID->EX captures {id_valid & id_rwe & id_dest!=0, id_dest, id_load} when stall=0. When stall=1 it captures an invalid entry (bubble).
- A source is "used" when it is selected (src1/src2) and the register is nonzero. Register 0 never causes a hazard or a forward.
- Stall conditions (combinational, when id_valid):
  - FORWARD=1: stall when EX.v & EX.load & EX.reg matches a used source.
  - FORWARD=0: stall when any valid entry in EX or MEM matches a used source. The WB entry is also checked when WB_BYPASS=0.
  - HI/LO: stall when id_hilo_rd & md_busy. Stall also when id_div & md_busy.
- Forwarding: fwd_a/fwd_b are registered and valid for the instruction in EX.
  - On a non-stalled ID->EX capture: 1 if EX.reg (becoming MEM) matches the source; otherwise 2 if MEM.reg (becoming WB) matches; otherwise 0.
  - The nearest producer wins. Selects are forced to 0 on a bubble and when FORWARD=0.
- Redirect: flush_if = ex_redirect, same cycle.
  - The delay-slot instruction in ID is preserved.
  - Redirect concurrent with stall: both assert; stall holds ID and flush_if still kills IF.
- Div FSM:
  - IDLE: on id_div & id_valid & !stall, pulse md_start, load counter with DIV_LAT-1, go to BUSY.
  - BUSY: md_busy=1 and the counter decrements each cycle. At 0, md_done=1 for that cycle, then go to IDLE.
  - md_busy deasserts the cycle after md_done, so a stalled MFHI issues that cycle.
- Reset mid-division: returns to IDLE the next edge; no md_done is produced.

Decomposition:
- Shared package/header (alongside the existing control bit defines) holds:
  - FWD_RF, FWD_MEM, FWD_WB encodings (0, 1, 2).
  - Div FSM state encodings.
  - Scoreboard entry field widths.
- One natural sub-module: div_sequencer, holding the IDLE/BUSY FSM and counter, with ports md_start/md_busy/md_done.

Test Plan:
- Load-use: LW r5 then ADD r6,r5,r7 with FORWARD=1 -> stall=1 for exactly 1 cycle, then fwd_a=2 for the ADD in EX.
- ALU chain: ADDU r3,r1,r2; SUB r4,r3,r3 -> no stall; fwd_a=1 and fwd_b=1 for the SUB. An intervening independent op gives fwd=2.
- r0 writes: ADDIU r0 then OR r1,r0,r0 -> no stall, fwd_a=fwd_b=0.
- Divide interlock: DIV with DIV_LAT=8, MFLO next -> md_start pulse; stall held while busy; md_done on the 8th cycle after start; MFLO issues the following cycle.
- Redirect during load-use stall: ex_redirect=1 in the stall cycle -> flush_if=1 and stall=1 in that cycle, and ID holds the delay slot.
- Reset mid-divide: rst_n=0 at busy cycle 4 -> md_busy=0 and outputs 0 after that edge, and no md_done pulse.
